// File: rtl/ez90_pkg.sv
// Shared front-end types and sizing constants for the ez90 core.
package ez90_pkg;

    localparam int unsigned EZ90_UOPQ_DEPTH = 8;

    typedef struct packed {
        logic [7:0]  tag;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [31:0] imm;
    } ez90_uop_t;

endpackage

// File: rtl/fe_uop_queue.sv
// Circular uop FIFO between the uop cache and decode/rename, with single-cycle flush
// and occupancy/almost-full outputs for fetch throttling.
module fe_uop_queue
    import ez90_pkg::*;
#(
    parameter int unsigned DEPTH        = EZ90_UOPQ_DEPTH,
    parameter int unsigned AFULL_THRESH = DEPTH - 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    input  ez90_uop_t                  in_uop,
    output logic                       in_ready,
    output logic                       out_valid,
    output ez90_uop_t                  out_uop,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       almost_full
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    ez90_uop_t     r_mem [DEPTH];

    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_pop;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    // Full: same slot index, opposite lap.
    assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                     (r_wr_ptr[AW] != r_rd_ptr[AW]);

    assign in_ready    = !w_full;
    assign out_valid   = !w_empty;
    assign out_uop     = r_mem[r_rd_ptr[AW-1:0]];
    assign count       = r_wr_ptr - r_rd_ptr;
    assign almost_full = (32'(count) >= AFULL_THRESH);

    assign w_push = in_valid && !w_full && !flush;
    assign w_pop  = !w_empty && out_ready && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (flush) begin
            r_rd_ptr <= r_wr_ptr;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
        end
    end

    // Storage is intentionally unreset; validity is carried by the pointers alone.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= in_uop;
        end
    end

endmodule

// File: tb/tb_fe_uop_queue.sv
// Directed and scoreboarded checks for fe_uop_queue at DEPTH=8.
module tb_fe_uop_queue;
    import ez90_pkg::*;

    logic       clk;
    logic       rst;
    logic       flush;
    logic       in_valid;
    ez90_uop_t  in_uop;
    logic       in_ready;
    logic       out_valid;
    ez90_uop_t  out_uop;
    logic       out_ready;
    logic [3:0] count;
    logic       almost_full;

    int n_checks;
    int n_errors;

    fe_uop_queue #(
        .DEPTH        (8),
        .AFULL_THRESH (6)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_uop      (in_uop),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_uop     (out_uop),
        .out_ready   (out_ready),
        .count       (count),
        .almost_full (almost_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, obs, exp, $time);
        end
    endtask

    function automatic ez90_uop_t mk(input logic [7:0] t);
        ez90_uop_t u;
        u.tag    = t;
        u.opcode = t[6:0];
        u.rd     = t[4:0];
        u.imm    = {4{t}};
        return u;
    endfunction

    logic [7:0] model_q[$];
    logic [7:0] seq;
    logic       p_push;
    logic       p_pop;

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_uop    = mk(8'd0);
        out_ready = 1'b0;

        #12;
        check("rst_count", 32'(count), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_afull", 32'(almost_full), 0);
        @(negedge clk);
        rst = 1'b0;

        // Push 1..3 with consumer stalled; head must hold.
        for (int i = 1; i <= 3; i++) begin
            in_valid = 1'b1;
            in_uop   = mk(8'(i));
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("hold_count", 32'(count), 3);
        check("hold_tag0", 32'(out_uop.tag), 1);
        @(negedge clk);
        check("hold_tag1", 32'(out_uop.tag), 1);
        check("hold_count1", 32'(count), 3);
        out_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            check("drain_valid", 32'(out_valid), 1);
            check("drain_tag", 32'(out_uop.tag), 32'(i));
            @(negedge clk);
        end
        check("drain_empty", 32'(out_valid), 0);
        out_ready = 1'b0;

        // Fill to full, watch almost_full threshold, then refuse a ninth uop.
        for (int k = 1; k <= 8; k++) begin
            in_valid = 1'b1;
            in_uop   = mk(8'(9 + k));
            @(negedge clk);
            check("fill_count", 32'(count), 32'(k));
            check("fill_afull", 32'(almost_full), (k >= 6) ? 32'd1 : 32'd0);
        end
        check("full_in_ready", 32'(in_ready), 0);
        in_uop = mk(8'd99);
        @(negedge clk);
        check("full_count", 32'(count), 8);
        check("full_in_ready2", 32'(in_ready), 0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("full_drain_tag", 32'(out_uop.tag), 32'(10 + i));
            @(negedge clk);
        end
        check("full_drain_empty", 32'(out_valid), 0);
        check("full_drain_count", 32'(count), 0);

        // Continuous streaming: one cycle latency, count steady at 1.
        for (int i = 0; i < 100; i++) begin
            in_valid = 1'b1;
            in_uop   = mk(8'(i));
            @(negedge clk);
            check("stream_valid", 32'(out_valid), 1);
            check("stream_tag", 32'(out_uop.tag), 32'(i));
            check("stream_count", 32'(count), 1);
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("stream_end_empty", 32'(out_valid), 0);
        out_ready = 1'b0;

        // Flush with concurrent push and pop.
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_uop   = mk(8'(40 + i));
            @(negedge clk);
        end
        check("pre_flush_count", 32'(count), 4);
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_uop    = mk(8'd77);
        out_ready = 1'b1;
        check("flush_in_ready", 32'(in_ready), 1);
        @(negedge clk);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("flush_count", 32'(count), 0);
        check("flush_out_valid", 32'(out_valid), 0);
        in_valid = 1'b1;
        in_uop   = mk(8'd50);
        @(negedge clk);
        in_valid = 1'b0;
        check("post_flush_tag", 32'(out_uop.tag), 50);
        check("post_flush_count", 32'(count), 1);
        out_ready = 1'b1;
        @(negedge clk);
        check("post_flush_empty", 32'(out_valid), 0);

        // Random stalls against a scoreboard, crossing the pointer wrap many times.
        model_q.delete();
        seq = 8'd100;
        for (int c = 0; c < 200; c++) begin
            in_valid  = ($urandom_range(0, 9) < 6);
            out_ready = ($urandom_range(0, 9) < 5);
            in_uop    = mk(seq);
            p_push    = in_valid && (model_q.size() < 8);
            p_pop     = out_ready && (model_q.size() > 0);
            @(negedge clk);
            if (p_pop) void'(model_q.pop_front());
            if (p_push) begin
                model_q.push_back(seq);
                seq = seq + 8'd1;
            end
            check("rand_count", 32'(count), 32'(model_q.size()));
            check("rand_valid", 32'(out_valid), (model_q.size() != 0) ? 32'd1 : 32'd0);
            if (model_q.size() != 0) check("rand_tag", 32'(out_uop.tag), 32'(model_q[0]));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) @(negedge clk);
        check("rand_drained", 32'(out_valid), 0);
        out_ready = 1'b0;

        // Asynchronous reset between edges with five entries buffered.
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_uop   = mk(8'(60 + i));
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("pre_rst_count", 32'(count), 5);
        #2;
        rst = 1'b1;
        #1;
        check("arst_count", 32'(count), 0);
        check("arst_out_valid", 32'(out_valid), 0);
        check("arst_in_ready", 32'(in_ready), 1);
        check("arst_afull", 32'(almost_full), 0);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b1;
        in_uop   = mk(8'd70);
        @(negedge clk);
        in_valid = 1'b0;
        check("post_rst_count", 32'(count), 1);
        check("post_rst_tag", 32'(out_uop.tag), 70);
        check("post_rst_imm", out_uop.imm, 32'h46464646);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
